// File: rtl/nrisc_mem_arbiter_if.sv
// Request/response bundle between two requesters (fetch, data), the arbiter and one memory port.
// slave = arbiter view, master = requesters plus memory model.
interface nrisc_mem_arbiter_if #(
  parameter int TAM = 16
);
  logic           if_req;
  logic [TAM-1:0] if_addr;
  logic           if_ack;
  logic [TAM-1:0] if_rdata;
  logic           d_req;
  logic           d_we;
  logic [TAM-1:0] d_addr;
  logic [TAM-1:0] d_wdata;
  logic           d_ack;
  logic [TAM-1:0] d_rdata;
  logic           err;
  logic           mem_req;
  logic           mem_we;
  logic [TAM-1:0] mem_addr;
  logic [TAM-1:0] mem_wdata;
  logic [TAM-1:0] mem_rdata;
  logic           mem_ack;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_ack, if_rdata, d_ack, d_rdata, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_ack, if_rdata, d_ack, d_rdata, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/nrisc_mem_arbiter.sv
// Fetch/data arbiter onto one memory port: IDLE -> BUSY -> RESP, min 3 cycles per transfer.
// Data has priority; fetch wins after STARVE_MAX consecutive losses. BUSY times out after TIMEOUT cycles.
module nrisc_mem_arbiter #(
  parameter int TAM        = 16,
  parameter int STARVE_MAX = 2,
  parameter int TIMEOUT    = 15
) (
  input logic                clk,
  input logic                rst,
  nrisc_mem_arbiter_if.slave bus
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;  // 1 = data port owns the transfer
  logic [SW-1:0]  starve_q, starve_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic [TAM-1:0] mem_addr_q, mem_addr_d;
  logic [TAM-1:0] mem_wdata_q, mem_wdata_d;
  logic           if_ack_q, if_ack_d;
  logic           d_ack_q, d_ack_d;
  logic           err_q, err_d;
  logic [TAM-1:0] if_rdata_q, if_rdata_d;
  logic [TAM-1:0] d_rdata_q, d_rdata_d;
  logic           grant_if;
  logic           timed_out;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    tcnt_d      = tcnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    grant_if    = 1'b0;
    timed_out   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          grant_if = bus.if_req && (!bus.d_req || starve_q == SW'(STARVE_MAX));
          if (grant_if) begin
            owner_d     = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
          end else begin
            owner_d     = 1'b1;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            if (bus.if_req && starve_q != SW'(STARVE_MAX))
              starve_d = starve_q + SW'(1);
          end
          mem_req_d = 1'b1;
          tcnt_d    = '0;
          state_d   = BUSY;
        end
      end

      BUSY: begin
        tcnt_d = tcnt_q + TW'(1);
        // A memory ack landing on the final timeout cycle still counts as success.
        if (bus.mem_ack || tcnt_q == TW'(TIMEOUT - 1)) begin
          timed_out = !bus.mem_ack;
          if (owner_q) begin
            d_ack_d = 1'b1;
            if (timed_out)      d_rdata_d = '1;
            else if (!mem_we_q) d_rdata_d = bus.mem_rdata;
          end else begin
            if_ack_d = 1'b1;
            if (timed_out)      if_rdata_d = '1;
            else if (!mem_we_q) if_rdata_d = bus.mem_rdata;
          end
          err_d       = timed_out;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          state_d     = RESP;
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      tcnt_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      tcnt_q      <= tcnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.err       = err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule
